blood_abnormality_detector: RTL and testbench

//   Registered classifier that flags a blood sample as abnormal when its pH

---
 rtl/blood_abnormality_detector_if.sv | 54 +++++
 rtl/blood_abnormality_detector.sv | 104 ++++++++++
 tb/tb_blood_abnormality_detector.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/blood_abnormality_detector_if.sv
// ---------------------------------------------------------------------------
// blood_abnormality_detector_if
//   Sample bus between the sensor front end and the abnormality classifier.
//   Optional feature macro: BLOOD_ABN_COUNT_EN (adds abnormalCount).
//
//   Signals
//     bloodPH           PH_W    unsigned pH code of current sample
//     bloodType         TYPE_W  blood type code (000 O, 001 A, 010 B, 011 AB)
//     bloodAbnormality  1       registered abnormal flag
//     abnormalCount     8       saturating abnormal-sample counter (optional)
//
//   Modports
//     master  sensor side: drives the sample, observes the result
//     slave   classifier side: receives the sample, drives the result
// ---------------------------------------------------------------------------
interface blood_abnormality_detector_if #(
    parameter int unsigned PH_W   = 4,
    parameter int unsigned TYPE_W = 3
);
    logic [PH_W-1:0]   bloodPH;
    logic [TYPE_W-1:0] bloodType;
    logic              bloodAbnormality;
`ifdef BLOOD_ABN_COUNT_EN
    logic [7:0]        abnormalCount;
`endif

`ifdef BLOOD_ABN_COUNT_EN
    modport master (
        output bloodPH,
        output bloodType,
        input  bloodAbnormality,
        input  abnormalCount
    );

    modport slave (
        input  bloodPH,
        input  bloodType,
        output bloodAbnormality,
        output abnormalCount
    );
`else
    modport master (
        output bloodPH,
        output bloodType,
        input  bloodAbnormality
    );

    modport slave (
        input  bloodPH,
        input  bloodType,
        output bloodAbnormality
    );
`endif
endinterface

// File: rtl/blood_abnormality_detector.sv
// ---------------------------------------------------------------------------
// blood_abnormality_detector
//   Registered classifier: flags a sample abnormal when its pH lies outside
//   the inclusive [MIN, MAX] window of its blood type. One sample per clock,
//   result visible one cycle after the input edge. Type codes with bit 2 set
//   are invalid and always flagged.
//
//   Optional feature macro: BLOOD_ABN_COUNT_EN
//     defined   -> 8-bit saturating count of abnormal samples on abnormalCount
//     undefined -> counter and port absent
//
//   Ports
//     clk    in  system clock, rising edge
//     rst_n  in  asynchronous active-low reset
//     bus    blood_abnormality_detector_if.slave
//              bloodPH / bloodType in, bloodAbnormality (/ abnormalCount) out
// ---------------------------------------------------------------------------
module blood_abnormality_detector #(
    parameter int unsigned     PH_W   = 4,
    parameter int unsigned     TYPE_W = 3,
    parameter logic [PH_W-1:0] O_MIN  = PH_W'(3),
    parameter logic [PH_W-1:0] O_MAX  = PH_W'(6),
    parameter logic [PH_W-1:0] A_MIN  = PH_W'(4),
    parameter logic [PH_W-1:0] A_MAX  = PH_W'(7),
    parameter logic [PH_W-1:0] B_MIN  = PH_W'(5),
    parameter logic [PH_W-1:0] B_MAX  = PH_W'(6),
    parameter logic [PH_W-1:0] AB_MIN = PH_W'(2),
    parameter logic [PH_W-1:0] AB_MAX = PH_W'(5)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    blood_abnormality_detector_if.slave   bus
);

    typedef enum logic [1:0] {
        TYPE_O  = 2'b00,
        TYPE_A  = 2'b01,
        TYPE_B  = 2'b10,
        TYPE_AB = 2'b11
    } blood_type_e;

    logic [PH_W-1:0] ph_min;
    logic [PH_W-1:0] ph_max;
    logic            abn;
    logic            abn_d;
    logic            abn_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        ph_min = O_MIN;
        ph_max = O_MAX;
        case (blood_type_e'(bus.bloodType[1:0]))
            TYPE_O:  begin ph_min = O_MIN;  ph_max = O_MAX;  end
            TYPE_A:  begin ph_min = A_MIN;  ph_max = A_MAX;  end
            TYPE_B:  begin ph_min = B_MIN;  ph_max = B_MAX;  end
            TYPE_AB: begin ph_min = AB_MIN; ph_max = AB_MAX; end
            default: begin ph_min = O_MIN;  ph_max = O_MAX;  end
        endcase

        // A misconfigured window (MIN > MAX) flags every pH, because one of
        // the two compares is then always true.
        abn   = bus.bloodType[2]
              | (bus.bloodPH < ph_min)
              | (bus.bloodPH > ph_max);
        abn_d = abn;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abn_q <= 1'b0;
        end else begin
            abn_q <= abn_d;
        end
    end

    assign bus.bloodAbnormality = abn_q;

`ifdef BLOOD_ABN_COUNT_EN
    logic [7:0] count_d;
    logic [7:0] count_q;

    // Counts on the same edge that loads the abnormal flag; sticks at 255.
    always_comb begin
        count_d = count_q;
        if (abn && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.abnormalCount = count_q;
`endif

endmodule

// File: tb/tb_blood_abnormality_detector.sv
// ---------------------------------------------------------------------------
// tb_blood_abnormality_detector
//   Directed self-checking bench for blood_abnormality_detector. Expected
//   values are hand-computed from the per-type pH windows:
//     O [3,6]  A [4,7]  B [5,6]  AB [2,5]  types 100..111 always abnormal.
//   Counter checks are compiled in only with BLOOD_ABN_COUNT_EN.
// ---------------------------------------------------------------------------
module tb_blood_abnormality_detector;

    logic clk;
    logic rst_n;

    int n_compared   = 0;
    int n_mismatched = 0;

    blood_abnormality_detector_if #(.PH_W(4), .TYPE_W(3)) bus ();

    blood_abnormality_detector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one sample, let one rising edge take it, check the flag 1 ns later.
    task automatic apply(input logic [3:0] ph, input logic [2:0] ty,
                         input logic exp_abn, input string tag);
        bus.bloodPH   = ph;
        bus.bloodType = ty;
        @(posedge clk);
        #1;
        check(tag, int'(bus.bloodAbnormality), int'(exp_abn));
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.bloodPH   = 4'd5;
        bus.bloodType = 3'b100;

        // ---------------- reset ----------------
        #3 rst_n = 1'b0;
        #1;
        check("reset_async", int'(bus.bloodAbnormality), 0);
`ifdef BLOOD_ABN_COUNT_EN
        check("reset_count", int'(bus.abnormalCount), 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", int'(bus.bloodAbnormality), 0);
`ifdef BLOOD_ABN_COUNT_EN
        check("reset_hold_count", int'(bus.abnormalCount), 0);
`endif
        rst_n = 1'b1;

        // ---------------- type O sweep [3,6] ----------------
        apply(4'd2, 3'b000, 1'b1, "O_ph2");
        apply(4'd3, 3'b000, 1'b0, "O_ph3");
        apply(4'd4, 3'b000, 1'b0, "O_ph4");
        apply(4'd5, 3'b000, 1'b0, "O_ph5");
        apply(4'd6, 3'b000, 1'b0, "O_ph6");
        apply(4'd7, 3'b000, 1'b1, "O_ph7");

        // ---------------- type B sweep [5,6] ----------------
        apply(4'd4, 3'b010, 1'b1, "B_ph4");
        apply(4'd5, 3'b010, 1'b0, "B_ph5");
        apply(4'd6, 3'b010, 1'b0, "B_ph6");
        apply(4'd7, 3'b010, 1'b1, "B_ph7");

        // ---------------- type A sweep [4,7] ----------------
        apply(4'd3, 3'b001, 1'b1, "A_ph3");
        apply(4'd4, 3'b001, 1'b0, "A_ph4");
        apply(4'd7, 3'b001, 1'b0, "A_ph7");
        apply(4'd8, 3'b001, 1'b1, "A_ph8");

        // ---------------- type AB sweep [2,5] ----------------
        apply(4'd1, 3'b011, 1'b1, "AB_ph1");
        apply(4'd2, 3'b011, 1'b0, "AB_ph2");
        apply(4'd5, 3'b011, 1'b0, "AB_ph5");
        apply(4'd6, 3'b011, 1'b1, "AB_ph6");

        // ---------------- invalid types, pH in every window ----------------
        apply(4'd5, 3'b100, 1'b1, "inv_100");
        apply(4'd5, 3'b101, 1'b1, "inv_101");
        apply(4'd5, 3'b110, 1'b1, "inv_110");
        apply(4'd5, 3'b111, 1'b1, "inv_111");

        // ---------------- extreme codes ----------------
        apply(4'd0,  3'b000, 1'b1, "O_ph0");
        apply(4'd15, 3'b001, 1'b1, "A_ph15");

        // ---------------- one-cycle latency ----------------
        apply(4'd5, 3'b000, 1'b0, "lat_normal");
        bus.bloodPH = 4'd9;
        #2;
        check("lat_no_early_change", int'(bus.bloodAbnormality), 0);
        @(posedge clk);
        #1;
        check("lat_after_edge", int'(bus.bloodAbnormality), 1);

        // ---------------- reset mid-stream ----------------
        apply(4'd12, 3'b000, 1'b1, "mid_pre");
        rst_n = 1'b0;
        #1;
        check("mid_async_drop", int'(bus.bloodAbnormality), 0);
`ifdef BLOOD_ABN_COUNT_EN
        check("mid_count_clear", int'(bus.abnormalCount), 0);
`endif
        #2 rst_n = 1'b1;
        #1;
        check("mid_still_low", int'(bus.bloodAbnormality), 0);
        apply(4'd12, 3'b000, 1'b1, "mid_resume");

`ifdef BLOOD_ABN_COUNT_EN
        // ---------------- saturating counter ----------------
        // Count is 1 from mid_resume; clear it for a clean run.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("cnt_reset", int'(bus.abnormalCount), 0);
        rst_n = 1'b1;
        apply(4'd5, 3'b000, 1'b0, "cnt_normal_flag");
        check("cnt_normal_hold0", int'(bus.abnormalCount), 0);
        for (int k = 1; k <= 300; k++) begin
            apply(4'd15, 3'b000, 1'b1, "cnt_abn_flag");
            check($sformatf("cnt_step%0d", k), int'(bus.abnormalCount),
                  (k > 255) ? 255 : k);
        end
        apply(4'd4, 3'b000, 1'b0, "cnt_sat_normal_flag");
        check("cnt_sat_hold", int'(bus.abnormalCount), 255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
